// File: rtl/uart_tx_arbiter_if.sv
// Byte-handshake bundle between the message sources, the arbiter and the UART TX core.
// The slave modport is the arbiter's view; master is the sources/UART side.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 3
);
  logic [N_REQ-1:0]   req;
  logic [N_REQ-1:0]   src_tx_start;
  logic [8*N_REQ-1:0] src_tx_data;
  logic [N_REQ-1:0]   grant;
  logic [N_REQ-1:0]   src_tx_done;
  logic               tx_start;
  logic [7:0]         tx_data;
  logic               tx_done;
  logic               busy;
  logic               timeout_err;

  modport slave (
    input  req, src_tx_start, src_tx_data, tx_done,
    output grant, src_tx_done, tx_start, tx_data, busy, timeout_err
  );

  modport master (
    output req, src_tx_start, src_tx_data, tx_done,
    input  grant, src_tx_done, tx_start, tx_data, busy, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular owner of a single UART transmitter, with a
// watchdog that revokes and masks a source that holds the grant without sending.
module uart_tx_arbiter #(
  parameter int N_REQ   = 3,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  uart_tx_arbiter_if.slave        bus
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, OWN, BYTE, DRAIN} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [N_REQ-1:0] mask_q, mask_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [WW-1:0]    wdog_q, wdog_d, wdog_inc;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             busy_q, busy_d;
  logic             to_err_q, to_err_d;

  logic             owner_req;
  logic             owner_start;
  logic [7:0]       owner_data;
  logic [N_REQ-1:0] eligible;
  logic             win_found;
  logic [PW-1:0]    win_idx;

  // ptr_q always names the current (or, in DRAIN, the former) owner.
  assign owner_req   = bus.req[ptr_q];
  assign owner_start = bus.src_tx_start[ptr_q];
  assign owner_data  = bus.src_tx_data[8*ptr_q +: 8];
  assign eligible    = bus.req & ~mask_q;
  assign wdog_inc    = (wdog_q == WD_LIMIT) ? wdog_q : wdog_q + 1'b1;

  // Round-robin search starting just after the last winner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!win_found && eligible[(int'(ptr_q) + i) % N_REQ]) begin
        win_found = 1'b1;
        win_idx   = PW'((int'(ptr_q) + i) % N_REQ);
      end
    end
  end

  always_comb begin
    // NOTE: every next-state signal gets a default before the case so no path
    // leaves one unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    ptr_d      = ptr_q;
    mask_d     = mask_q & bus.req;
    grant_d    = grant_q;
    done_d     = '0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    to_err_d   = 1'b0;
    wdog_d     = wdog_q;

    unique case (state_q)
      IDLE: begin
        wdog_d = '0;
        if (win_found) begin
          ptr_d   = win_idx;
          grant_d = N_REQ'(1) << win_idx;
          state_d = OWN;
        end
      end

      OWN: begin
        if (owner_start) begin
          // A start always wins, even against a same-cycle release or expiry.
          tx_start_d = 1'b1;
          tx_data_d  = owner_data;
          wdog_d     = '0;
          if (owner_req) begin
            state_d = BYTE;
          end else begin
            grant_d = '0;
            state_d = DRAIN;
          end
        end else if (!owner_req) begin
          grant_d = '0;
          state_d = IDLE;
        end else if (wdog_inc == WD_LIMIT) begin
          grant_d        = '0;
          to_err_d       = 1'b1;
          mask_d[ptr_q]  = 1'b1;
          wdog_d         = wdog_inc;
          state_d        = IDLE;
        end else begin
          wdog_d = wdog_inc;
        end
      end

      BYTE: begin
        if (bus.tx_done) begin
          done_d = N_REQ'(1) << ptr_q;
          if (owner_req) begin
            state_d = OWN;
          end else begin
            grant_d = '0;
            state_d = IDLE;
          end
        end else if (!owner_req) begin
          grant_d = '0;
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        if (bus.tx_done) begin
          done_d  = N_REQ'(1) << ptr_q;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= PW'(N_REQ - 1);
      mask_q     <= '0;
      grant_q    <= '0;
      done_q     <= '0;
      wdog_q     <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      to_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      mask_q     <= mask_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      wdog_q     <= wdog_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      to_err_q   <= to_err_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.src_tx_done = done_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = to_err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench for uart_tx_arbiter: a round-robin message model
// predicts grant order, byte stream and done pulses; a monitor checks them.
module tb_uart_tx_arbiter;
  localparam int N  = 3;
  localparam int TO = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(N)) bus ();

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [N-1:0] exp_grant_q[$];
  logic [7:0]   exp_byte_q[$];
  int           exp_done_q[$];
  int           exp_to_q[$];

  int         ptr_m;
  int         fixed_dly = 0;
  int         inj_pct   = 0;
  int         msg_len[N];
  logic [7:0] msg_b[N][4];
  int         msg_mode[N];   // 0: release after last done, 1: release with last start, 2: release mid-byte

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_bound(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // UART core stand-in: one tx_done pulse a fixed or random delay after each tx_start.
  initial begin
    int dly;
    bus.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.tx_start) begin
        dly = (fixed_dly > 0) ? fixed_dly : int'($urandom_range(3, 12));
        repeat (dly - 1) @(negedge clk);
        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.tx_done = 1'b0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents an event.
  initial begin
    logic [N-1:0] prev_g;
    int           outstanding;
    int           tmp;
    prev_g      = '0;
    outstanding = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_g      = '0;
        outstanding = 0;
      end else begin
        if (bus.tx_start) begin
          if (exp_byte_q.size() == 0) check("tx_start_unexpected", 32'(bus.tx_start), 32'd0);
          else check("tx_data", 32'(bus.tx_data), 32'(exp_byte_q.pop_front()));
          outstanding++;
        end
        if (bus.src_tx_done != '0) begin
          if (exp_done_q.size() == 0) check("src_tx_done_unexpected", 32'(bus.src_tx_done), 32'd0);
          else begin
            tmp = exp_done_q.pop_front();
            check("src_tx_done", 32'(bus.src_tx_done), 32'(1) << tmp);
          end
          outstanding--;
        end
        if (bus.timeout_err) begin
          if (exp_to_q.size() == 0) check("timeout_unexpected", 32'(bus.timeout_err), 32'd0);
          else begin
            tmp = exp_to_q.pop_front();
            check("timeout_revoked_owner", 32'(prev_g), 32'(1) << tmp);
            check("timeout_grant_dropped", 32'(bus.grant), 32'd0);
          end
        end
        if (bus.grant != prev_g && bus.grant != '0) begin
          check("grant_gap", 32'(prev_g), 32'd0);
          check("grant_after_drain", 32'(outstanding), 32'd0);
          check("busy_with_grant", 32'(bus.busy), 32'd1);
          if (exp_grant_q.size() == 0) check("grant_unexpected", 32'(bus.grant), 32'd0);
          else check("grant_order", 32'(bus.grant), 32'(exp_grant_q.pop_front()));
        end
        prev_g = bus.grant;
      end
    end
  end

  // One cycle of waiting, optionally with a 0xFF start pulse from a non-owner.
  task automatic step(input int o);
    int j;
    j = int'($urandom_range(0, N - 1));
    if (int'($urandom_range(0, 99)) < inj_pct && j != o && !bus.grant[j]) begin
      bus.src_tx_data[8*j +: 8] = 8'hFF;
      bus.src_tx_start[j]       = 1'b1;
    end
    @(negedge clk);
    bus.src_tx_start = '0;
  endtask

  task automatic send_msg(input int o);
    bit got;
    for (int k = 0; k < msg_len[o]; k++) begin
      bit last;
      last = (k == msg_len[o] - 1);
      repeat ($urandom_range(0, 2)) step(o);
      bus.src_tx_data[8*o +: 8] = msg_b[o][k];
      bus.src_tx_start[o]       = 1'b1;
      if (last && msg_mode[o] == 1) bus.req[o] = 1'b0;
      @(negedge clk);
      bus.src_tx_start = '0;
      check("start_latency", 32'(bus.tx_start), 32'd1);
      if (last && msg_mode[o] == 1) check("grant_drop_with_start", 32'(bus.grant), 32'd0);
      if (last && msg_mode[o] == 2) begin
        bus.req[o] = 1'b0;
        @(negedge clk);
        check("grant_drop_mid_byte", 32'(bus.grant), 32'd0);
        check("busy_in_drain", 32'(bus.busy), 32'd1);
      end
      got = 1'b0;
      for (int c = 0; c < 200; c++) begin
        if (bus.src_tx_done[o]) begin
          got = 1'b1;
          break;
        end
        step(o);
      end
      if (!got) fail_bound("wait_src_tx_done");
    end
    if (msg_mode[o] == 0) begin
      bus.req[o] = 1'b0;
      @(negedge clk);
      check("grant_drop_after_req", 32'(bus.grant), 32'd0);
    end
  endtask

  // Raise req for every source in 'set' at once; the model orders them round-robin.
  task automatic run_round(input logic [N-1:0] set);
    logic [N-1:0] left;
    int           ord[$];
    int           p;
    int           owner;
    bit           got;
    left = set;
    p    = ptr_m;
    while (left != '0) begin
      p = (p + 1) % N;
      if (left[p]) begin
        ord.push_back(p);
        left[p] = 1'b0;
      end
    end
    ptr_m = ord[ord.size() - 1];
    foreach (ord[i]) begin
      exp_grant_q.push_back(N'(1) << ord[i]);
      for (int k = 0; k < msg_len[ord[i]]; k++) begin
        exp_byte_q.push_back(msg_b[ord[i]][k]);
        exp_done_q.push_back(ord[i]);
      end
    end
    bus.req = bus.req | set;
    @(negedge clk);
    check("grant_latency", 32'(bus.grant), 32'(1) << ord[0]);
    for (int k = 0; k < ord.size(); k++) begin
      got = 1'b0;
      for (int c = 0; c < 50; c++) begin
        if (bus.grant != '0) begin
          got = 1'b1;
          break;
        end
        step(-1);
      end
      if (!got) begin
        fail_bound("wait_grant");
        bus.req = '0;
        return;
      end
      owner = 0;
      for (int i = 0; i < N; i++) if (bus.grant[i]) owner = i;
      send_msg(owner);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic watchdog_test();
    bit got;
    bit regrant;
    exp_grant_q.push_back(N'(3'b010));
    exp_grant_q.push_back(N'(3'b010));
    exp_to_q.push_back(1);
    bus.req[1] = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.grant != '0) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) fail_bound("wd_wait_grant");
    check("wd_grant", 32'(bus.grant), 32'b010);
    got = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.timeout_err) begin
        got = 1'b1;
        check("wd_delay", 32'(c), 32'(TO));
        break;
      end
    end
    if (!got) fail_bound("wd_wait_timeout");
    check("wd_grant_revoked", 32'(bus.grant), 32'd0);
    @(negedge clk);
    check("wd_pulse_single", 32'(bus.timeout_err), 32'd0);
    regrant = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.grant != '0) regrant = 1'b1;
    end
    check("wd_masked_no_regrant", 32'(regrant), 32'd0);
    bus.req[1] = 1'b0;
    @(negedge clk);
    bus.req[1] = 1'b1;
    @(negedge clk);
    check("wd_regrant_after_low", 32'(bus.grant), 32'b010);
    bus.req[1] = 1'b0;
    @(negedge clk);
    check("wd_release", 32'(bus.grant), 32'd0);
    ptr_m = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic reset_mid_byte_test();
    exp_grant_q.push_back(N'(3'b001));
    exp_byte_q.push_back(8'h5A);
    fixed_dly  = 10;
    bus.req[0] = 1'b1;
    @(negedge clk);
    check("rst_test_grant", 32'(bus.grant), 32'b001);
    bus.src_tx_data[7:0] = 8'h5A;
    bus.src_tx_start[0]  = 1'b1;
    @(negedge clk);
    bus.src_tx_start = '0;
    check("rst_test_tx_start", 32'(bus.tx_start), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_grant", 32'(bus.grant), 32'd0);
    check("rst_mid_src_tx_done", 32'(bus.src_tx_done), 32'd0);
    check("rst_mid_tx_start", 32'(bus.tx_start), 32'd0);
    check("rst_mid_tx_data", 32'(bus.tx_data), 32'd0);
    check("rst_mid_busy", 32'(bus.busy), 32'd1 - 32'd1);
    check("rst_mid_timeout_err", 32'(bus.timeout_err), 32'd0);
    bus.req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ptr_m = N - 1;
    repeat (20) @(negedge clk);
    check("rst_after_busy", 32'(bus.busy), 32'd0);
    fixed_dly = 0;
  endtask

  initial begin
    #500_000;
    $display("FAIL global_time_limit: simulation did not finish (t=%0t)", $time);
    $fatal(1, "time limit");
  end

  initial begin
    logic [N-1:0] set;
    bus.req          = '0;
    bus.src_tx_start = '0;
    bus.src_tx_data  = '0;
    ptr_m            = N - 1;
    repeat (3) @(negedge clk);
    check("reset_grant", 32'(bus.grant), 32'd0);
    check("reset_src_tx_done", 32'(bus.src_tx_done), 32'd0);
    check("reset_tx_start", 32'(bus.tx_start), 32'd0);
    check("reset_tx_data", 32'(bus.tx_data), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_timeout_err", 32'(bus.timeout_err), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single source, three bytes, UART done ten cycles after each start.
    fixed_dly   = 10;
    msg_len[0]  = 3;
    msg_b[0][0] = 8'h31;
    msg_b[0][1] = 8'h32;
    msg_b[0][2] = 8'h0A;
    msg_mode[0] = 0;
    run_round(3'b001);
    fixed_dly = 0;

    // All three request together, twice: round-robin order.
    repeat (2) begin
      for (int i = 0; i < N; i++) begin
        msg_len[i]  = 1;
        msg_b[i][0] = 8'($urandom_range(0, 254));
        msg_mode[i] = 0;
      end
      run_round(3'b111);
    end

    // Non-owner injection while owner 1 has bytes in flight.
    inj_pct     = 100;
    msg_len[1]  = 2;
    msg_b[1][0] = 8'h41;
    msg_b[1][1] = 8'h42;
    msg_mode[1] = 0;
    run_round(3'b010);
    inj_pct = 0;

    // Owner 2 releases mid-byte while source 0 waits.
    msg_len[2]  = 1;
    msg_b[2][0] = 8'h77;
    msg_mode[2] = 2;
    msg_len[0]  = 1;
    msg_b[0][0] = 8'h10;
    msg_mode[0] = 0;
    run_round(3'b101);

    // Randomized rounds.
    inj_pct = 30;
    repeat (30) begin
      set = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        msg_len[i]  = int'($urandom_range(1, 3));
        msg_mode[i] = int'($urandom_range(0, 2));
        for (int k = 0; k < 4; k++) msg_b[i][k] = 8'($urandom_range(0, 254));
      end
      run_round(set);
    end
    inj_pct = 0;

    watchdog_test();
    reset_mid_byte_test();

    repeat (10) @(negedge clk);
    check("leftover_grants", 32'(exp_grant_q.size()), 32'd0);
    check("leftover_bytes", 32'(exp_byte_q.size()), 32'd0);
    check("leftover_dones", 32'(exp_done_q.size()), 32'd0);
    check("leftover_timeouts", 32'(exp_to_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmitter among up to N_REQ message sources: matrix display, prompt/menu printer, error reporter. A source owns the transmitter for a whole message, so bytes from different messages never interleave. Arbitration is round-robin, and a watchdog revokes ownership from a source that stalls. The block sits between the message sources and the UART TX core, on the tx_start/tx_data/tx_done byte handshake.

## Interface
- N_REQ, 3: number of requesters (2..8).
- TIMEOUT, 1_000_000: idle-owner cycles before the grant is revoked (≥2).
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N_REQ  level per source; held high for the whole message.
- src_tx_start  in  N_REQ  per-source byte-send pulse.
- src_tx_data  in  8*N_REQ  per-source byte; source i uses bits [8i+7:8i].
- grant  out  N_REQ  one-hot ownership, or all zero.
- src_tx_done  out  N_REQ  per-source byte-complete pulse.
- tx_start  out  1  to UART core, single-cycle pulse.
- tx_data  out  8  to UART core, valid with tx_start and held until the next tx_start.
- tx_done  in  1  from UART core, single-cycle pulse per byte.
- busy  out  1  high whenever any grant is active or a byte is in flight.
- timeout_err  out  1  single-cycle pulse on watchdog revoke.

## Operation
- States:
  - IDLE: no owner.
  - OWN: owner present, no byte in flight.
  - BYTE: owner present, byte in flight.
  - DRAIN: owner released, last byte in flight.
- IDLE: if any unmasked req is set, grant the first set req searching from ptr+1 modulo N_REQ, set ptr to the winner, go to OWN. If none is set, stay.
- OWN, owner's src_tx_start=1:
  - Latch the owner's data.
  - Next cycle, tx_start=1 and tx_data=the latched byte.
  - Go to BYTE and clear the watchdog.
- OWN, owner's req=0 (and no start): drop grant, go to IDLE.
- OWN, watchdog reaches TIMEOUT:
  - Drop grant.
  - Pulse timeout_err.
  - Set mask[owner].
  - Go to IDLE.
- BYTE:
  - On tx_done, pulse src_tx_done[owner] the next cycle.
  - Return to OWN if req[owner]=1, else go to IDLE.
  - If the owner's req drops before tx_done, grant drops immediately and the state goes to DRAIN.
- DRAIN: on tx_done, pulse src_tx_done[former owner] and go to IDLE.
- src_tx_start from non-owners is ignored in every state. Owner's src_tx_start in BYTE/DRAIN is ignored; no queueing.
- tx_done arriving in IDLE/OWN is ignored.
- Mask: mask[i] clears when req[i]=0. A masked source is never granted.
- Watchdog: counts cycles in OWN only and saturates at TIMEOUT. It has a width of clog2(TIMEOUT+1).
- ptr (clog2(N_REQ) bits) wraps from N_REQ-1 to 0.

## Timing
- Reset values:
  - grant=0, src_tx_done=0, tx_start=0, tx_data=0, busy=0, timeout_err=0.
  - State IDLE, ptr=N_REQ-1 (so source 0 wins first), mask=0, watchdog=0.
- Reset mid-byte: all outputs return to reset values at once. The pending tx_done after reset is ignored (state IDLE).
- All outputs are registered.
- Grant latency: req at edge k produces grant at edge k+1.
- Start latency: owner's src_tx_start at edge k produces tx_start at edge k+1.
- Done latency: tx_done at edge k produces src_tx_done at edge k+1.
- Release to next grant: at least one cycle in IDLE, so two grants are never adjacent without a zero-grant cycle.
- Simultaneous src_tx_start and req fall in OWN: the byte is sent, and the state goes to DRAIN.
- Simultaneous watchdog expiry and owner src_tx_start: start wins, watchdog clears.
- busy = (state≠IDLE), registered.

## Test plan
- Single source, 3 bytes: req[0]=1 from reset, sends 0x31, 0x32, 0x0A with tx_done 10 cycles after each tx_start.
  - grant=001 one cycle after req.
  - tx_data sequence 31,32,0A.
  - Three src_tx_done[0] pulses.
  - grant drops one cycle after req falls.
- Round-robin: req=111 held, each owner sends 1 byte and drops req, then re-raises it.
  - Grants in order 001, 010, 100, 001.
  - At least one zero-grant cycle between each.
- Non-owner injection: owner 1 in BYTE; source 0 pulses src_tx_start with 0xFF.
  - No extra tx_start.
  - tx_data never 0xFF.
  - src_tx_done only on bit 1.
- Release mid-byte: owner 2 drops req after tx_start, before tx_done.
  - grant=000 next cycle, state DRAIN.
  - src_tx_done[2] still pulses once.
  - req[0] is granted only after that pulse.
- Watchdog: TIMEOUT=8, source 1 granted, no starts.
  - timeout_err pulses once, 8 cycles after grant.
  - grant=000.
  - Source 1 is not regranted while req[1] stays high, and is regranted after req[1] goes low then high.
- Reset mid-byte: rst_n low during BYTE.
  - All outputs reset immediately.
  - A late tx_done causes no src_tx_done pulse.
